tlb_lookup_arbiter: RTL and testbench

Shares the CPU's single TLB lookup port between instruction-address translation and data-address translation. Instruction requests come from the fetch stage when its translation prediction is flushed (page crossing, mask change, or mapping change); data requests come from the memory stage. The block arbitrates with bounded starvation, sequences each lookup through the registered TLB, and returns the physical address, page mask and fault flags to the winning requester.

---
 rtl/tlb_lookup_arbiter_if.sv | 47 ++++
 rtl/tlb_lookup_arbiter.sv | 111 +++++++++++
 tb/tb_tlb_lookup_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_lookup_arbiter_if.sv
// Bundles the fetch, memory-stage and TLB lookup signals around the shared TLB lookup port.
// The arbiter takes the slave view; requesters and the TLB together take the master view.
interface tlb_lookup_arbiter_if;
  logic        i_req;
  logic [31:0] i_vaddr;
  logic        i_cancel;
  logic        i_ack;
  logic        i_valid;
  logic [31:0] i_paddr;
  logic [15:0] i_pagemask;
  logic        i_miss;

  logic        d_req;
  logic [31:0] d_vaddr;
  logic        d_write;
  logic        d_ack;
  logic        d_valid;
  logic [31:0] d_paddr;
  logic        d_miss;
  logic        d_mod;

  logic        tlb_busy;
  logic        tlb_lookup;
  logic [31:0] tlb_vaddr;
  logic        tlb_hit;
  logic        tlb_dirty;
  logic [31:0] tlb_paddr;
  logic [15:0] tlb_pagemask;

  modport slave (
    input  i_req, i_vaddr, i_cancel,
    output i_ack, i_valid, i_paddr, i_pagemask, i_miss,
    input  d_req, d_vaddr, d_write,
    output d_ack, d_valid, d_paddr, d_miss, d_mod,
    input  tlb_busy, tlb_hit, tlb_dirty, tlb_paddr, tlb_pagemask,
    output tlb_lookup, tlb_vaddr
  );

  modport master (
    output i_req, i_vaddr, i_cancel,
    input  i_ack, i_valid, i_paddr, i_pagemask, i_miss,
    output d_req, d_vaddr, d_write,
    input  d_ack, d_valid, d_paddr, d_miss, d_mod,
    output tlb_busy, tlb_hit, tlb_dirty, tlb_paddr, tlb_pagemask,
    input  tlb_lookup, tlb_vaddr
  );
endinterface

// File: rtl/tlb_lookup_arbiter.sv
// Shares one registered TLB lookup port between instruction and data translation, data first,
// with the instruction side forced through after STARVE_LIMIT consecutive data grants.
module tlb_lookup_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tlb_lookup_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WAIT    = 1'b1;
  localparam logic       OWNER_D    = 1'b0;
  localparam logic       OWNER_I    = 1'b1;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [0:0]  r_state;
  logic        r_owner;
  logic [3:0]  r_starve;
  logic        r_d_write;
  logic        r_i_valid;
  logic        r_i_miss;
  logic [31:0] r_i_paddr;
  logic [15:0] r_i_pagemask;
  logic        r_d_valid;
  logic        r_d_miss;
  logic        r_d_mod;
  logic [31:0] r_d_paddr;

  logic        w_i_elig;
  logic        w_can_grant;
  logic        w_grant_i;
  logic        w_grant_d;
  logic [3:0]  w_starve_next;

  // Grants are gated by rst_n so acks read 0 while reset is held.
  always_comb begin
    w_i_elig    = bus.i_req & ~bus.i_cancel;
    w_can_grant = rst_n & (r_state == ST_IDLE) & ~bus.tlb_busy;
    w_grant_i   = w_can_grant & w_i_elig & (~bus.d_req | (r_starve == STARVE_MAX));
    w_grant_d   = w_can_grant & bus.d_req & ~w_grant_i;
  end

  always_comb begin
    w_starve_next = r_starve;
    if (w_grant_i || ((r_state == ST_IDLE) && !bus.i_req)) begin
      w_starve_next = '0;
    end else if (w_grant_d && w_i_elig && (r_starve != STARVE_MAX)) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  assign bus.i_ack      = w_grant_i;
  assign bus.d_ack      = w_grant_d;
  assign bus.tlb_lookup = w_grant_i | w_grant_d;
  assign bus.tlb_vaddr  = w_grant_i ? bus.i_vaddr : (w_grant_d ? bus.d_vaddr : 32'h0);

  assign bus.i_valid    = r_i_valid;
  assign bus.i_paddr    = r_i_paddr;
  assign bus.i_pagemask = r_i_pagemask;
  assign bus.i_miss     = r_i_miss;
  assign bus.d_valid    = r_d_valid;
  assign bus.d_paddr    = r_d_paddr;
  assign bus.d_miss     = r_d_miss;
  assign bus.d_mod      = r_d_mod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWNER_D;
      r_starve     <= '0;
      r_d_write    <= 1'b0;
      r_i_valid    <= 1'b0;
      r_i_miss     <= 1'b0;
      r_i_paddr    <= '0;
      r_i_pagemask <= '0;
      r_d_valid    <= 1'b0;
      r_d_miss     <= 1'b0;
      r_d_mod      <= 1'b0;
      r_d_paddr    <= '0;
    end else begin
      r_starve  <= w_starve_next;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_grant_i || w_grant_d) begin
          r_state   <= ST_WAIT;
          r_owner   <= w_grant_i ? OWNER_I : OWNER_D;
          r_d_write <= w_grant_d & bus.d_write;
        end
      end else begin
        r_state <= ST_IDLE;
        if (r_owner == OWNER_I) begin
          // A fetch redirect during the lookup drops the result; outputs keep old data.
          if (!bus.i_cancel) begin
            r_i_valid    <= 1'b1;
            r_i_paddr    <= bus.tlb_hit ? bus.tlb_paddr : 32'h0;
            r_i_pagemask <= bus.tlb_pagemask;
            r_i_miss     <= ~bus.tlb_hit;
          end
        end else begin
          r_d_valid <= 1'b1;
          r_d_paddr <= bus.tlb_hit ? bus.tlb_paddr : 32'h0;
          r_d_miss  <= ~bus.tlb_hit;
          r_d_mod   <= r_d_write & bus.tlb_hit & ~bus.tlb_dirty;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Scoreboarded bench for tlb_lookup_arbiter: grants push expected results, valid pulses pop them,
// and per-scenario tasks check grant timing, arbitration order, cancel, busy and reset.
module tb_tlb_lookup_arbiter;

  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlb_lookup_arbiter_if bus ();

  tlb_lookup_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_i;
    bit          killed;
    int          due;
    logic [31:0] paddr;
    logic [15:0] pm;
    logic        miss;
    logic        mod_f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lookup_prev = 1'b0;

  // TLB response the bench model returns for the next lookup.
  logic        rsp_hit = 1'b1;
  logic        rsp_dirty = 1'b1;
  logic [31:0] rsp_paddr = 32'h0;
  logic [15:0] rsp_pm = 16'h0;

  // TLB model plus scoreboard: result only driven in the cycle after a lookup, junk otherwise.
  always @(negedge clk) begin
    exp_t e;
    logic exp_iv;
    logic exp_dv;
    #1;
    if (lookup_prev) begin
      bus.tlb_hit      = rsp_hit;
      bus.tlb_dirty    = rsp_dirty;
      bus.tlb_paddr    = rsp_paddr;
      bus.tlb_pagemask = rsp_pm;
    end else begin
      bus.tlb_hit      = 1'b0;
      bus.tlb_dirty    = 1'b0;
      bus.tlb_paddr    = 32'hDEAD_BEEF;
      bus.tlb_pagemask = 16'hBAD0;
    end
    #1;
    cyc++;
    if (rst_n) begin
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (!e.killed) begin
          exp_iv = e.is_i;
          exp_dv = !e.is_i;
        end
      end
      checks++;
      if (bus.i_valid !== exp_iv || bus.d_valid !== exp_dv) begin
        errors++;
        $display("FAIL sb_valid cyc %0d: got i_valid=%b d_valid=%b expected %b %b",
                 cyc, bus.i_valid, bus.d_valid, exp_iv, exp_dv);
      end
      if (exp_iv) begin
        checks++;
        if (bus.i_paddr !== e.paddr || bus.i_pagemask !== e.pm || bus.i_miss !== e.miss) begin
          errors++;
          $display("FAIL sb_iresult: got %h/%h/%b expected %h/%h/%b", bus.i_paddr,
                   bus.i_pagemask, bus.i_miss, e.paddr, e.pm, e.miss);
        end
      end
      if (exp_dv) begin
        checks++;
        if (bus.d_paddr !== e.paddr || bus.d_miss !== e.miss || bus.d_mod !== e.mod_f) begin
          errors++;
          $display("FAIL sb_dresult: got %h/%b/%b expected %h/%b/%b", bus.d_paddr,
                   bus.d_miss, bus.d_mod, e.paddr, e.miss, e.mod_f);
        end
      end
      if (bus.i_ack || bus.d_ack) begin
        e.is_i   = bus.i_ack;
        e.killed = 1'b0;
        e.due    = cyc + 2;
        e.paddr  = rsp_hit ? rsp_paddr : 32'h0;
        e.pm     = rsp_pm;
        e.miss   = !rsp_hit;
        e.mod_f  = !bus.i_ack && bus.d_write && rsp_hit && !rsp_dirty;
        sb.push_back(e);
      end
      lookup_prev = bus.tlb_lookup;
    end else begin
      lookup_prev = 1'b0;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.i_valid, bus.d_valid, bus.i_miss, bus.d_miss, bus.d_mod,
         bus.tlb_lookup, bus.i_paddr, bus.d_paddr, bus.i_pagemask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_instr();
    @(negedge clk);
    rsp_hit = 1'b1; rsp_paddr = 32'h0123_4000; rsp_pm = 16'h0;
    bus.i_req = 1'b1; bus.i_vaddr = 32'h0040_1000;
    #3;
    checks++;
    if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0 || bus.tlb_lookup !== 1'b1 ||
        bus.tlb_vaddr !== 32'h0040_1000) begin
      errors++;
      $display("FAIL single_grant: got ack=%b lookup=%b vaddr=%h expected 1 1 00401000",
               bus.i_ack, bus.tlb_lookup, bus.tlb_vaddr);
    end
    @(negedge clk);
    bus.i_req = 1'b0;
    #3;
    checks++;
    if (bus.i_ack !== 1'b0 || bus.tlb_lookup !== 1'b0 || bus.i_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: got ack=%b lookup=%b valid=%b expected 0 0 0",
               bus.i_ack, bus.tlb_lookup, bus.i_valid);
    end
    @(negedge clk);
    #3;
    checks++;
    if (bus.i_valid !== 1'b1 || bus.i_paddr !== 32'h0123_4000 || bus.tlb_vaddr !== 32'h0) begin
      errors++;
      $display("FAIL single_result: got valid=%b paddr=%h tlb_vaddr=%h expected 1 01234000 0",
               bus.i_valid, bus.i_paddr, bus.tlb_vaddr);
    end
    @(negedge clk);
    #3;
    checks++;
    if (bus.i_valid !== 1'b0 || bus.i_paddr !== 32'h0123_4000) begin
      errors++;
      $display("FAIL single_pulse: got valid=%b paddr=%h expected 0 01234000",
               bus.i_valid, bus.i_paddr);
    end
  endtask

  // Holds both requests and checks the D..D,I pattern with one grant every two cycles.
  task automatic contention_run(input int ngrants);
    int g;
    int last;
    bit exp_i;
    g = 0;
    last = -2;
    @(negedge clk);
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    bus.d_vaddr = 32'h1000_0000; bus.i_vaddr = 32'h0040_3000;
    for (int c = 0; c < 2 * ngrants; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      if (bus.i_ack || bus.d_ack) begin
        exp_i = ((g % (STARVE + 1)) == STARVE);
        checks++;
        if (bus.i_ack !== exp_i || bus.d_ack !== !exp_i ||
            bus.tlb_vaddr !== (exp_i ? 32'h0040_3000 : 32'h1000_0000)) begin
          errors++;
          $display("FAIL contention_order grant %0d: got i_ack=%b d_ack=%b vaddr=%h expected i=%b",
                   g, bus.i_ack, bus.d_ack, bus.tlb_vaddr, exp_i);
        end
        checks++;
        if (c - last != 2) begin
          errors++;
          $display("FAIL contention_spacing grant %0d: got gap %0d expected 2", g, c - last);
        end
        last = c;
        g++;
      end
    end
    checks++;
    if (g != ngrants) begin
      errors++;
      $display("FAIL contention_count: got %0d grants expected %0d", g, ngrants);
    end
    @(negedge clk);
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    rsp_hit = 1'b1; rsp_dirty = 1'b1; rsp_paddr = 32'h0777_0000; rsp_pm = 16'h00F0;
    contention_run(10);
  endtask

  task automatic test_store_clean();
    logic        t_wr[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        t_hit[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        t_dirty[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_pa[4]   = '{32'h0ABC_D000, 32'h5555_5000, 32'h0000_7000, 32'h0BEE_F000};
    logic        t_mod[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_epa[4]  = '{32'h0ABC_D000, 32'h0, 32'h0000_7000, 32'h0BEE_F000};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rsp_hit = t_hit[k]; rsp_dirty = t_dirty[k]; rsp_paddr = t_pa[k];
      bus.d_req = 1'b1; bus.d_write = t_wr[k]; bus.d_vaddr = 32'h2000_0000 + 32'(k);
      #3;
      checks++;
      if (bus.d_ack !== 1'b1) begin
        errors++;
        $display("FAIL store_ack case %0d: got %b expected 1", k, bus.d_ack);
      end
      @(negedge clk);
      bus.d_req = 1'b0; bus.d_write = ~t_wr[k];
      @(negedge clk);
      bus.d_write = 1'b0;
      #3;
      checks++;
      if (bus.d_valid !== 1'b1 || bus.d_mod !== t_mod[k] || bus.d_miss !== !t_hit[k] ||
          bus.d_paddr !== t_epa[k] || bus.i_valid !== 1'b0) begin
        errors++;
        $display("FAIL store_result case %0d: got v=%b mod=%b miss=%b pa=%h expected 1 %b %b %h",
                 k, bus.d_valid, bus.d_mod, bus.d_miss, bus.d_paddr, t_mod[k], !t_hit[k],
                 t_epa[k]);
      end
    end
  endtask

  task automatic test_cancel();
    @(negedge clk);
    rsp_hit = 1'b1; rsp_dirty = 1'b1; rsp_paddr = 32'h0200_0000;
    bus.i_req = 1'b1; bus.i_vaddr = 32'h0040_2000;
    #3;
    checks++;
    if (bus.i_ack !== 1'b1) begin
      errors++;
      $display("FAIL cancel_grant: got i_ack=%b expected 1", bus.i_ack);
    end
    @(negedge clk);
    bus.i_req = 1'b0; bus.i_cancel = 1'b1;
    bus.d_req = 1'b1; bus.d_vaddr = 32'h2000_0040;
    if (sb.size() > 0) sb[sb.size() - 1].killed = 1'b1;
    #3;
    checks++;
    if (bus.d_ack !== 1'b0 || bus.tlb_lookup !== 1'b0) begin
      errors++;
      $display("FAIL cancel_wait: got d_ack=%b lookup=%b expected 0 0", bus.d_ack, bus.tlb_lookup);
    end
    @(negedge clk);
    bus.i_cancel = 1'b0;
    #3;
    checks++;
    if (bus.i_valid !== 1'b0 || bus.d_ack !== 1'b1 || bus.tlb_vaddr !== 32'h2000_0040) begin
      errors++;
      $display("FAIL cancel_follow: got i_valid=%b d_ack=%b vaddr=%h expected 0 1 20000040",
               bus.i_valid, bus.d_ack, bus.tlb_vaddr);
    end
    @(negedge clk);
    bus.d_req = 1'b0; bus.i_cancel = 1'b1;
    @(negedge clk);
    bus.i_cancel = 1'b0;
    #3;
    checks++;
    if (bus.d_valid !== 1'b1) begin
      errors++;
      $display("FAIL cancel_data: got d_valid=%b expected 1", bus.d_valid);
    end
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_cancel = 1'b1;
    #3;
    checks++;
    if (bus.i_ack !== 1'b0 || bus.tlb_lookup !== 1'b0) begin
      errors++;
      $display("FAIL cancel_same: got i_ack=%b lookup=%b expected 0 0", bus.i_ack, bus.tlb_lookup);
    end
    @(negedge clk);
    bus.i_req = 1'b0; bus.i_cancel = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy();
    @(negedge clk);
    rsp_hit = 1'b1; rsp_paddr = 32'h0300_0000;
    bus.tlb_busy = 1'b1; bus.d_req = 1'b1; bus.d_vaddr = 32'h2000_0080;
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++;
      if (bus.d_ack !== 1'b0 || bus.tlb_lookup !== 1'b0) begin
        errors++;
        $display("FAIL busy_block cycle %0d: got d_ack=%b lookup=%b expected 0 0",
                 k, bus.d_ack, bus.tlb_lookup);
      end
      @(negedge clk);
    end
    bus.tlb_busy = 1'b0;
    #3;
    checks++;
    if (bus.d_ack !== 1'b1 || bus.tlb_lookup !== 1'b1) begin
      errors++;
      $display("FAIL busy_release: got d_ack=%b lookup=%b expected 1 1", bus.d_ack, bus.tlb_lookup);
    end
    @(negedge clk);
    bus.d_req = 1'b0; bus.tlb_busy = 1'b1;
    @(negedge clk);
    bus.tlb_busy = 1'b0;
    #3;
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_paddr !== 32'h0300_0000) begin
      errors++;
      $display("FAIL busy_in_wait: got d_valid=%b paddr=%h expected 1 03000000",
               bus.d_valid, bus.d_paddr);
    end
  endtask

  task automatic test_reset_mid();
    rsp_hit = 1'b1; rsp_paddr = 32'h0444_0000; rsp_pm = 16'h0F00;
    @(negedge clk);
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.i_valid, bus.d_valid, bus.i_miss, bus.d_miss, bus.d_mod,
         bus.tlb_lookup, bus.i_paddr, bus.d_paddr, bus.i_pagemask} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got d_paddr=%h i_pagemask=%h ack=%b%b expected all 0",
               bus.d_paddr, bus.i_pagemask, bus.i_ack, bus.d_ack);
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    checks++;
    if (bus.d_valid !== 1'b0 || bus.i_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_novalid: got %b %b expected 0 0", bus.i_valid, bus.d_valid);
    end
    contention_run(5);
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_vaddr = '0; bus.i_cancel = 1'b0;
    bus.d_req = 1'b0; bus.d_vaddr = '0; bus.d_write = 1'b0;
    bus.tlb_busy = 1'b0;
    bus.tlb_hit = 1'b0; bus.tlb_dirty = 1'b0; bus.tlb_paddr = '0; bus.tlb_pagemask = '0;
    test_reset();
    test_single_instr();
    test_contention();
    test_store_clean();
    test_cancel();
    test_busy();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding results expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
